// File: rtl/cpu_ddr_1_pipeline_bridge.sv
// DDR-side pipeline stage of the CPU-to-DDR clock-crossing bridge.
// Registers the command path (one-entry holding register) and the read
// response path, and caps the number of reads in flight to the controller
// so returning data always fits in the crossing bridge's response FIFO.
module cpu_ddr_1_pipeline_bridge #(
  parameter int ADDR_W      = 24,
  parameter int DATA_W      = 32,
  parameter int MAX_PENDING = 7,
  parameter int CNT_W       = 3
) (
  input  logic                clk,
  input  logic                reset,
  // upstream (crossing bridge master side)
  input  logic [ADDR_W-1:0]   s_address,
  input  logic [DATA_W/8-1:0] s_byteenable,
  input  logic                s_read,
  input  logic                s_write,
  input  logic [DATA_W-1:0]   s_writedata,
  output logic                s_waitrequest,
  output logic [DATA_W-1:0]   s_readdata,
  output logic                s_readdatavalid,
  output logic                s_endofpacket,
  // downstream (DDR controller slave)
  output logic [ADDR_W-1:0]   m_address,
  output logic [DATA_W/8-1:0] m_byteenable,
  output logic                m_read,
  output logic                m_write,
  output logic [DATA_W-1:0]   m_writedata,
  input  logic                m_waitrequest,
  input  logic [DATA_W-1:0]   m_readdata,
  input  logic                m_readdatavalid,
  input  logic                m_endofpacket,
  // debug / status
  output logic [CNT_W-1:0]    pending_count,
  output logic                err_unexpected_rdv
);

  localparam int                BE_W           = DATA_W / 8;
  localparam logic [CNT_W-1:0]  LP_MAX_PENDING = CNT_W'(MAX_PENDING);

  // command holding register
  logic                r_cmd_valid;
  logic [ADDR_W-1:0]   r_cmd_addr;
  logic [BE_W-1:0]     r_cmd_be;
  logic [DATA_W-1:0]   r_cmd_wdata;
  logic                r_cmd_rd;
  logic                r_cmd_wr;

  // outstanding-read tracking
  logic [CNT_W-1:0]    r_pending;
  logic                r_err_rdv;

  // response registers
  logic [DATA_W-1:0]   r_rsp_data;
  logic                r_rsp_valid;
  logic                r_rsp_eop;

  // handshake decode
  logic                w_below_max;
  logic                w_issue;
  logic                w_rd_issue;
  logic                w_accept;
  logic                w_req;

  // A held read may only go out while the controller has room below the cap;
  // writes produce no response and bypass the cap entirely.
  assign w_below_max = (r_pending < LP_MAX_PENDING);
  assign w_issue     = r_cmd_valid & ~m_waitrequest & (r_cmd_wr | w_below_max);
  assign w_rd_issue  = w_issue & r_cmd_rd;

  // The register can take a new command when empty or when draining this
  // cycle, which gives one command per cycle when the controller keeps up.
  assign s_waitrequest = reset | (r_cmd_valid & ~w_issue);
  assign w_req         = s_read | s_write;
  assign w_accept      = w_req & ~s_waitrequest;

  assign m_address    = r_cmd_addr;
  assign m_byteenable = r_cmd_be;
  assign m_writedata  = r_cmd_wdata;
  assign m_read       = r_cmd_valid & r_cmd_rd & w_below_max;
  assign m_write      = r_cmd_valid & r_cmd_wr;

  assign pending_count      = r_pending;
  assign err_unexpected_rdv = r_err_rdv;

  assign s_readdata      = r_rsp_data;
  assign s_readdatavalid = r_rsp_valid;
  assign s_endofpacket   = r_rsp_eop;

  // Command register: load on accept, empty on issue without a refill.
  // A request with both read and write set is treated as a write.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cmd_valid <= 1'b0;
      r_cmd_addr  <= '0;
      r_cmd_be    <= '0;
      r_cmd_wdata <= '0;
      r_cmd_rd    <= 1'b0;
      r_cmd_wr    <= 1'b0;
    end else if (w_accept) begin
      r_cmd_valid <= 1'b1;
      r_cmd_addr  <= s_address;
      r_cmd_be    <= s_byteenable;
      r_cmd_wdata <= s_writedata;
      r_cmd_rd    <= s_read & ~s_write;
      r_cmd_wr    <= s_write;
    end else if (w_issue) begin
      r_cmd_valid <= 1'b0;
    end
  end

  // Outstanding-read counter: up on read issue, down on returned data.
  // Data with nothing outstanding leaves the count at zero.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_pending <= '0;
    end else begin
      unique case ({w_rd_issue, m_readdatavalid})
        2'b10:   r_pending <= r_pending + 1'b1;
        2'b01:   if (r_pending != '0) r_pending <= r_pending - 1'b1;
        default: r_pending <= r_pending;
      endcase
    end
  end

  // Sticky flag for read data arriving with no read outstanding.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_err_rdv <= 1'b0;
    end else if (m_readdatavalid && (r_pending == '0)) begin
      r_err_rdv <= 1'b1;
    end
  end

  // Response stage: fixed one-cycle delay, data held between beats.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_rsp_valid <= 1'b0;
      r_rsp_eop   <= 1'b0;
      r_rsp_data  <= '0;
    end else begin
      r_rsp_valid <= m_readdatavalid;
      r_rsp_eop   <= m_endofpacket & m_readdatavalid;
      if (m_readdatavalid) r_rsp_data <= m_readdata;
    end
  end

endmodule

// File: tb/tb_cpu_ddr_1_pipeline_bridge.sv
// Self-checking bench for cpu_ddr_1_pipeline_bridge: a table of single
// commands with varying stall lengths, then directed sequences for the
// read cap, response path, counter corner cases and mid-transaction reset.
module tb_cpu_ddr_1_pipeline_bridge;

  localparam int ADDR_W      = 24;
  localparam int DATA_W      = 32;
  localparam int MAX_PENDING = 7;
  localparam int CNT_W       = 3;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic [ADDR_W-1:0] s_address = '0;
  logic [3:0]        s_byteenable = '0;
  logic              s_read = 1'b0;
  logic              s_write = 1'b0;
  logic [DATA_W-1:0] s_writedata = '0;
  logic              s_waitrequest;
  logic [DATA_W-1:0] s_readdata;
  logic              s_readdatavalid;
  logic              s_endofpacket;
  logic [ADDR_W-1:0] m_address;
  logic [3:0]        m_byteenable;
  logic              m_read;
  logic              m_write;
  logic [DATA_W-1:0] m_writedata;
  logic              m_waitrequest = 1'b0;
  logic [DATA_W-1:0] m_readdata = '0;
  logic              m_readdatavalid = 1'b0;
  logic              m_endofpacket = 1'b0;
  logic [CNT_W-1:0]  pending_count;
  logic              err_unexpected_rdv;

  always #5 clk = ~clk;

  cpu_ddr_1_pipeline_bridge #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_PENDING(MAX_PENDING), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .reset(reset),
    .s_address(s_address), .s_byteenable(s_byteenable), .s_read(s_read),
    .s_write(s_write), .s_writedata(s_writedata), .s_waitrequest(s_waitrequest),
    .s_readdata(s_readdata), .s_readdatavalid(s_readdatavalid),
    .s_endofpacket(s_endofpacket),
    .m_address(m_address), .m_byteenable(m_byteenable), .m_read(m_read),
    .m_write(m_write), .m_writedata(m_writedata), .m_waitrequest(m_waitrequest),
    .m_readdata(m_readdata), .m_readdatavalid(m_readdatavalid),
    .m_endofpacket(m_endofpacket),
    .pending_count(pending_count), .err_unexpected_rdv(err_unexpected_rdv)
  );

  typedef struct {
    logic [23:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic        rd;
    logic        wr;
  } cmd_t;

  typedef struct {
    logic [31:0] data;
    logic        eop;
  } rsp_t;

  typedef struct {
    logic        rd;
    logic        wr;
    logic [23:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    int          waits;
    logic        exp_rd;
    logic        exp_wr;
  } vec_t;

  cmd_t cmd_q[$];
  rsp_t rsp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   rd_issues = 0;
  int   exp_pending = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_cmd(input logic [23:0] a, input logic [3:0] be,
                          input logic [31:0] d, input logic rd, input logic wr);
    cmd_t c;
    c.addr = a; c.be = be; c.wdata = d; c.rd = rd; c.wr = wr;
    cmd_q.push_back(c);
  endtask

  task automatic set_rdv(input logic [31:0] d, input logic eop);
    rsp_t r;
    m_readdatavalid = 1'b1;
    m_readdata      = d;
    m_endofpacket   = eop;
    r.data = d; r.eop = eop;
    rsp_q.push_back(r);
  endtask

  task automatic clr_rdv();
    m_readdatavalid = 1'b0;
    m_endofpacket   = 1'b0;
  endtask

  // Scoreboard: every command issued downstream and every response
  // returned upstream is matched against the head of its queue.
  always @(negedge clk) begin
    if (!reset) begin
      if ((m_read || m_write) && !m_waitrequest) begin
        cmd_t e;
        if (m_read) rd_issues++;
        checks++;
        if (cmd_q.size() == 0) begin
          errors++;
          $display("FAIL sb_cmd: issue addr 0x%0h with no command expected", m_address);
        end else begin
          e = cmd_q.pop_front();
          chk("sb_addr", 32'(m_address), 32'(e.addr));
          chk("sb_be", 32'(m_byteenable), 32'(e.be));
          chk("sb_rd", 32'(m_read), 32'(e.rd));
          chk("sb_wr", 32'(m_write), 32'(e.wr));
          if (e.wr) chk("sb_wdata", m_writedata, e.wdata);
        end
      end
      if (s_readdatavalid) begin
        rsp_t r;
        checks++;
        if (rsp_q.size() == 0) begin
          errors++;
          $display("FAIL sb_rsp: readdatavalid 0x%0h with no response expected", s_readdata);
        end else begin
          r = rsp_q.pop_front();
          chk("sb_rdata", s_readdata, r.data);
          chk("sb_eop", 32'(s_endofpacket), 32'(r.eop));
        end
      end
    end
  end

  // One command: accept, hold for v.waits stall cycles, issue, then idle.
  task automatic run_vec(input vec_t v, input int idx);
    s_read = v.rd; s_write = v.wr; s_address = v.addr;
    s_byteenable = v.be; s_writedata = v.wdata;
    m_waitrequest = (v.waits > 0);
    @(negedge clk);
    chk($sformatf("v%0d_ready", idx), 32'(s_waitrequest), 32'd0);
    push_cmd(v.addr, v.be, v.wdata, v.exp_rd, v.exp_wr);
    step();
    s_read = 1'b0; s_write = 1'b0;
    for (int k = 0; k < v.waits; k++) begin
      @(negedge clk);
      chk($sformatf("v%0d_hold_rd", idx), 32'(m_read), 32'(v.exp_rd));
      chk($sformatf("v%0d_hold_wr", idx), 32'(m_write), 32'(v.exp_wr));
      chk($sformatf("v%0d_hold_addr", idx), 32'(m_address), 32'(v.addr));
      chk($sformatf("v%0d_hold_wdata", idx), m_writedata, v.wdata);
      chk($sformatf("v%0d_hold_swait", idx), 32'(s_waitrequest), 32'd1);
      step();
      if (k == v.waits - 1) m_waitrequest = 1'b0;
    end
    @(negedge clk);
    chk($sformatf("v%0d_issue_rd", idx), 32'(m_read), 32'(v.exp_rd));
    chk($sformatf("v%0d_issue_wr", idx), 32'(m_write), 32'(v.exp_wr));
    if (v.exp_rd) exp_pending++;
    step();
    @(negedge clk);
    chk($sformatf("v%0d_idle_rd", idx), 32'(m_read), 32'd0);
    chk($sformatf("v%0d_idle_wr", idx), 32'(m_write), 32'd0);
    chk($sformatf("v%0d_pending", idx), 32'(pending_count), 32'(exp_pending));
    step();
  endtask

  vec_t vecs[6];
  int   acc;
  int   stall_at;

  initial begin
    vecs[0] = '{rd:1'b0, wr:1'b1, addr:24'h000010, be:4'hF, wdata:32'hDEADBEEF, waits:0, exp_rd:1'b0, exp_wr:1'b1};
    vecs[1] = '{rd:1'b1, wr:1'b0, addr:24'h000020, be:4'hF, wdata:32'h0, waits:0, exp_rd:1'b1, exp_wr:1'b0};
    vecs[2] = '{rd:1'b0, wr:1'b1, addr:24'hABCDEF, be:4'h3, wdata:32'h0BADF00D, waits:5, exp_rd:1'b0, exp_wr:1'b1};
    vecs[3] = '{rd:1'b1, wr:1'b0, addr:24'h123456, be:4'hF, wdata:32'h0, waits:2, exp_rd:1'b1, exp_wr:1'b0};
    vecs[4] = '{rd:1'b1, wr:1'b1, addr:24'h000555, be:4'hC, wdata:32'h55AA55AA, waits:0, exp_rd:1'b0, exp_wr:1'b1};
    vecs[5] = '{rd:1'b0, wr:1'b1, addr:24'hFFFFFF, be:4'h1, wdata:32'h000000A5, waits:1, exp_rd:1'b0, exp_wr:1'b1};

    // reset state
    @(negedge clk);
    chk("rst_swait", 32'(s_waitrequest), 32'd1);
    step();
    step();
    reset = 1'b0;
    @(negedge clk);
    chk("rst_pending", 32'(pending_count), 32'd0);
    chk("rst_err", 32'(err_unexpected_rdv), 32'd0);
    chk("rst_srdv", 32'(s_readdatavalid), 32'd0);
    chk("rst_seop", 32'(s_endofpacket), 32'd0);
    chk("rst_mread", 32'(m_read), 32'd0);
    chk("rst_mwrite", 32'(m_write), 32'd0);
    chk("rst_swait_rel", 32'(s_waitrequest), 32'd0);
    step();

    // table of single commands
    for (int i = 0; i < 6; i++) run_vec(vecs[i], i);

    // return the two table reads
    set_rdv(32'h0000AAAA, 1'b0);
    step();
    set_rdv(32'h0000BBBB, 1'b1);
    step();
    clr_rdv();
    @(negedge clk);
    chk("drain_srdv", 32'(s_readdatavalid), 32'd1);
    chk("drain_pending", 32'(pending_count), 32'd0);
    step();

    // 10 back-to-back reads, no data returned: cap holds at 7
    rd_issues = 0;
    acc = 0;
    stall_at = -1;
    s_read = 1'b1; s_write = 1'b0; s_byteenable = 4'hF;
    for (int cyc = 0; cyc < 20 && acc < 10; cyc++) begin
      s_address = 24'h000100 + 24'(acc);
      @(negedge clk);
      if (!s_waitrequest) begin
        push_cmd(s_address, 4'hF, s_writedata, 1'b1, 1'b0);
        acc++;
      end else if (stall_at < 0) begin
        stall_at = acc;
      end
      step();
    end
    s_read = 1'b0;
    @(negedge clk);
    chk("cap_accepted", 32'(acc), 32'd8);
    chk("cap_stall_at", 32'(stall_at), 32'd8);
    chk("cap_issues", 32'(rd_issues), 32'd7);
    chk("cap_pending", 32'(pending_count), 32'd7);
    chk("cap_mread", 32'(m_read), 32'd0);
    chk("cap_swait", 32'(s_waitrequest), 32'd1);
    step();

    // one response frees a slot; held read issues the cycle after
    set_rdv(32'h12345678, 1'b1);
    @(negedge clk);
    chk("free_mread_before", 32'(m_read), 32'd0);
    step();
    clr_rdv();
    @(negedge clk);
    chk("free_srdv", 32'(s_readdatavalid), 32'd1);
    chk("free_sdata", s_readdata, 32'h12345678);
    chk("free_seop", 32'(s_endofpacket), 32'd1);
    chk("free_pending_dip", 32'(pending_count), 32'd6);
    chk("free_mread_issue", 32'(m_read), 32'd1);
    step();
    @(negedge clk);
    chk("free_pending", 32'(pending_count), 32'd7);
    chk("free_mread_after", 32'(m_read), 32'd0);
    chk("free_srdv_after", 32'(s_readdatavalid), 32'd0);
    step();

    // drain to 3, then simultaneous issue and response
    for (int i = 0; i < 4; i++) begin
      set_rdv(32'hA0000000 + 32'(i), 1'(i == 3));
      step();
    end
    clr_rdv();
    @(negedge clk);
    chk("sim_pending_pre", 32'(pending_count), 32'd3);
    step();
    s_read = 1'b1; s_address = 24'h000200;
    @(negedge clk);
    chk("sim_accept", 32'(s_waitrequest), 32'd0);
    push_cmd(24'h000200, 4'hF, s_writedata, 1'b1, 1'b0);
    step();
    s_read = 1'b0;
    set_rdv(32'hCAFE0001, 1'b0);
    @(negedge clk);
    chk("sim_mread", 32'(m_read), 32'd1);
    step();
    clr_rdv();
    @(negedge clk);
    chk("sim_pending", 32'(pending_count), 32'd3);
    step();

    // drain to 0, then unexpected data
    for (int i = 0; i < 3; i++) begin
      set_rdv(32'hB0000000 + 32'(i), 1'b0);
      step();
    end
    clr_rdv();
    @(negedge clk);
    chk("unexp_pending_pre", 32'(pending_count), 32'd0);
    chk("unexp_err_pre", 32'(err_unexpected_rdv), 32'd0);
    step();
    set_rdv(32'hBAD0BAD0, 1'b0);
    step();
    clr_rdv();
    @(negedge clk);
    chk("unexp_err", 32'(err_unexpected_rdv), 32'd1);
    chk("unexp_pending", 32'(pending_count), 32'd0);
    step();
    step();
    @(negedge clk);
    chk("unexp_err_sticky", 32'(err_unexpected_rdv), 32'd1);
    step();

    // build count=4 plus a stalled write, then reset for one cycle
    s_read = 1'b1;
    for (int i = 0; i < 4; i++) begin
      s_address = 24'h000300 + 24'(i);
      @(negedge clk);
      chk("rstm_accept", 32'(s_waitrequest), 32'd0);
      push_cmd(s_address, 4'hF, s_writedata, 1'b1, 1'b0);
      step();
    end
    s_read = 1'b0;
    step();
    s_write = 1'b1; s_address = 24'h000400; s_writedata = 32'h11112222;
    m_waitrequest = 1'b1;
    @(negedge clk);
    chk("rstm_wr_accept", 32'(s_waitrequest), 32'd0);
    step();
    s_write = 1'b0;
    @(negedge clk);
    chk("rstm_pending", 32'(pending_count), 32'd4);
    chk("rstm_mwrite", 32'(m_write), 32'd1);
    step();
    reset = 1'b1;
    m_readdatavalid = 1'b1; m_readdata = 32'hDEAD0000; m_endofpacket = 1'b1;
    @(negedge clk);
    chk("rstm_swait", 32'(s_waitrequest), 32'd1);
    step();
    reset = 1'b0;
    clr_rdv();
    m_waitrequest = 1'b0;
    @(negedge clk);
    chk("rstm_cnt0", 32'(pending_count), 32'd0);
    chk("rstm_err0", 32'(err_unexpected_rdv), 32'd0);
    chk("rstm_mwrite0", 32'(m_write), 32'd0);
    chk("rstm_mread0", 32'(m_read), 32'd0);
    chk("rstm_srdv0", 32'(s_readdatavalid), 32'd0);
    chk("rstm_seop0", 32'(s_endofpacket), 32'd0);
    chk("rstm_swait0", 32'(s_waitrequest), 32'd0);
    step();

    // first command after reset issues normally
    s_read = 1'b1; s_address = 24'h000500;
    @(negedge clk);
    chk("post_accept", 32'(s_waitrequest), 32'd0);
    push_cmd(24'h000500, 4'hF, s_writedata, 1'b1, 1'b0);
    step();
    s_read = 1'b0;
    @(negedge clk);
    chk("post_mread", 32'(m_read), 32'd1);
    chk("post_maddr", 32'(m_address), 32'h000500);
    step();
    @(negedge clk);
    chk("post_pending", 32'(pending_count), 32'd1);
    chk("post_mread_idle", 32'(m_read), 32'd0);
    step();
    set_rdv(32'h00000077, 1'b1);
    step();
    clr_rdv();
    step();
    @(negedge clk);
    chk("end_pending", 32'(pending_count), 32'd0);
    chk("end_cmd_q", 32'(cmd_q.size()), 32'd0);
    chk("end_rsp_q", 32'(rsp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
